// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
// The EX stage is the master; div_ctrl is the slave.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic                 annul;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stall;

    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  result, ready, stall
    );

    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output result, ready, stall
    );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU.
// It produces {HI = remainder, LO = quotient} and holds the pipeline stall while the divide runs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; the result register holds its last value
// DIVZERO | divisor was zero; the result is forced to 0 on exit
// BUSY    | one shift-subtract step per cycle, WIDTH steps in total
// DONE    | result valid, ready pulses for one cycle
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    div_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic               quot_neg;
    logic               rem_neg;
    logic [2*WIDTH-1:0] result;

    logic               accept;
    logic               divisor_zero;
    logic               last_step;
    logic [WIDTH-1:0]   dvd_abs;
    logic [WIDTH-1:0]   dvs_abs;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    always_comb begin
        accept       = (state == IDLE) && bus.start && !bus.annul;
        divisor_zero = (bus.divisor == '0);
        last_step    = (state == BUSY) && (cnt == LAST_STEP);

        dvd_abs = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_abs = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

        // The quotient register starts out holding the dividend; its MSB
        // shifts into the partial remainder as quotient bits fill from the LSB.
        rem_sh   = {rem, quo[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvs};
        qbit     = ~diff[WIDTH];
        rem_step = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = divisor_zero ? DIVZERO : BUSY;
                end
            end
            DIVZERO: begin
                state_nxt = bus.annul ? IDLE : DONE;
            end
            BUSY: begin
                if (bus.annul) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The result is loaded on the edge into DONE, so it is already valid in
    // the cycle where ready is high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            result   <= '0;
        end else begin
            if (accept && !divisor_zero) begin
                cnt      <= '0;
                rem      <= '0;
                quo      <= dvd_abs;
                dvs      <= dvs_abs;
                quot_neg <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                rem_neg  <= bus.signed_div & bus.dividend[WIDTH-1];
            end
            if ((state == BUSY) && !bus.annul) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 1'b1;
                if (last_step) begin
                    result <= {(rem_neg  ? -rem_step : rem_step),
                               (quot_neg ? -quo_step : quo_step)};
                end
            end
            if ((state == DIVZERO) && !bus.annul) begin
                result <= '0;
            end
        end
    end

    assign bus.result = result;
    assign bus.ready  = (state == DONE);
    assign bus.stall  = bus.start & ~bus.annul & ~bus.ready;

endmodule
